// File: rtl/ifetch_buf_pkg.sv
// Shared core constants and types for the instruction fetch buffer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ifetch_buf_pkg;

    // Native core word width and the canonical NOP (addi x0, x0, 0).
    localparam int          CORE_XLEN = 32;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    // Request-side state: IDLE has nothing pending, REQ holds one request on the bus.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_buf_fifo.sv
// Synchronous FIFO with push/pop/clear and full/empty/count status; head read straight from storage.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push when full is ignored unless a pop frees the slot in the same cycle; pop when empty is ignored.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    // Pointer update; clear wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are only observed behind a non-empty status so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ifetch_buf.sv
// Fetch unit: issues in-order word reads for accepted PCs and buffers {inst, pc} for decode.
// Latency: pc accept -> imem_req 1 cycle; imem_rvalid -> inst_valid 1 cycle.
// Backpressure: pc_ready is a credit check so responses always find a free slot; imem_rvalid is never stalled.
module ifetch_buf
    import ifetch_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = CORE_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic            fetch_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 3;

    fetch_state_t    state;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_tag;
    logic [AW:0]     outstanding;
    logic [AW:0]     drop_cnt;

    logic            grant;
    logic            accept;
    logic            req_held;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   out_sum;
    logic [CW-1:0]   drop_load;
    logic            resp_drop;
    logic            resp_keep;

    logic [2*XLEN-1:0] inst_head;
    logic              inst_empty;
    logic              inst_full;
    logic [AW:0]       inst_count;
    logic [XLEN-1:0]   tag_head;
    logic              tag_full;
    logic              tag_empty;
    logic [AW:0]       tag_count;
    logic              unused_status;

    assign req_held = (state == REQ);
    assign grant    = req_held & imem_gnt;

    // Every fetch that can still land in the FIFO holds a credit: granted, buffered, or on the bus.
    assign inflight = CW'(outstanding) + CW'(inst_count) + CW'(req_held);
    assign pc_ready = (~req_held | imem_gnt) & ~flush & (inflight < CW'(DEPTH));
    assign accept   = pc_valid & pc_ready;
    assign fetch_stall = pc_valid & ~pc_ready;

    assign imem_req  = req_held;
    assign imem_addr = req_addr;

    assign resp_drop = imem_rvalid & (drop_cnt != '0);
    assign resp_keep = imem_rvalid & (drop_cnt == '0) & ~flush;

    assign out_sum   = CW'(outstanding) + CW'(grant) - CW'(imem_rvalid & (outstanding != '0));
    // The held request cannot be withdrawn, so it joins the responses to be discarded.
    assign drop_load = CW'(outstanding) - CW'(imem_rvalid) + CW'(req_held);

    // Request FSM: capture address and tag on accept, hold them until granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_addr <= '0;
            req_tag  <= '0;
        end else if (accept) begin
            state    <= REQ;
            req_addr <= {pc[XLEN-1:2], 2'b00};
            req_tag  <= pc;
        end else if (grant) begin
            state    <= IDLE;
        end
    end

    // Granted-but-unreturned request count, saturating at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (out_sum > CW'(DEPTH)) begin
            outstanding <= (AW+1)'(DEPTH);
        end else begin
            outstanding <= out_sum[AW:0];
        end
    end

    // Responses still owed to killed fetches; reloaded on flush, consumed one per returned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= drop_load[AW:0];
        end else if (resp_drop) begin
            drop_cnt <= drop_cnt - (AW+1)'(1);
        end
    end

    // PC tags of granted requests, popped by every response in order (kept or dropped).
    ifetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (grant),
        .push_dat (req_tag),
        .pop      (imem_rvalid),
        .clear    (1'b0),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    // Instruction buffer presented to decode.
    ifetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (resp_keep),
        .push_dat ({imem_rdata, tag_head}),
        .pop      (inst_valid & inst_ready),
        .clear    (flush),
        .head_dat (inst_head),
        .full     (inst_full),
        .empty    (inst_empty),
        .count    (inst_count)
    );

    assign inst_valid = ~inst_empty;
    assign inst       = inst_valid ? inst_head[2*XLEN-1:XLEN] : XLEN'(NOP_INST);
    assign inst_pc    = inst_valid ? inst_head[XLEN-1:0]      : '0;

    assign unused_status = &{1'b0, tag_full, tag_empty, tag_count, inst_full};

endmodule

// File: tb/tb_ifetch_buf.sv
module tb_ifetch_buf;

    localparam int          DEPTH = 4;
    localparam int          XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] PAT   = 32'hA5A5_A5A5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            pc_ready;
    logic            flush;
    logic            fetch_stall;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    always #5 clk = ~clk;

    ifetch_buf #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .fetch_stall (fetch_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] resp_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_inst_q[$];
    logic        rv_en;
    logic        auto_pc;

    typedef struct {
        logic        pv;
        logic        ir;
        logic        gnt;
        logic        exp_pc_ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_ipc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    // Records this cycle's handshakes, crosses the clock edge, then updates PC source and memory model.
    task automatic advance();
        logic        acc;
        logic        gf;
        logic        rv;
        logic [31:0] ga;
        acc = pc_valid & pc_ready;
        gf  = imem_req & imem_gnt;
        ga  = imem_addr;
        rv  = imem_rvalid;
        if (inst_valid && inst_ready) begin
            pop_pc_q.push_back(inst_pc);
            pop_inst_q.push_back(inst);
        end
        @(posedge clk);
        #1;
        if (acc && auto_pc) pc = pc + 32'd4;
        if (rv && resp_q.size() > 0) void'(resp_q.pop_front());
        if (gf) resp_q.push_back(ga);
        if (rv_en && resp_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = resp_q[0] ^ PAT;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            to_sample();
            advance();
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        pc          = '0;
        pc_valid    = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        rv_en       = 1'b0;
        auto_pc     = 1'b1;
        resp_q.delete();
        pop_pc_q.delete();
        pop_inst_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_cnt;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, NOP};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, NOP};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, NOP};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, 32'hA5A5A5A5};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, 32'hA5A5A5A1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'hA5A5A5AD};

        // Reset values while rst_n is held low
        rst_n = 1'b0;
        pc = '0; pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        #3;
        chk("rst_imem_req",   32'(imem_req),   32'd0);
        chk("rst_imem_addr",  imem_addr,       32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc",    inst_pc,         32'd0);
        chk("rst_drop_cnt",   32'(dut.drop_cnt),    32'd0);
        chk("rst_outstanding",32'(dut.outstanding), 32'd0);

        // 1: streaming fetch, one per cycle, table-driven
        do_reset();
        rv_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pc_valid   = tbl[i].pv;
            inst_ready = tbl[i].ir;
            imem_gnt   = tbl[i].gnt;
            to_sample();
            chk($sformatf("t1_pc_ready[%0d]", i),   32'(pc_ready),   32'(tbl[i].exp_pc_ready));
            chk($sformatf("t1_imem_req[%0d]", i),   32'(imem_req),   32'(tbl[i].exp_req));
            chk($sformatf("t1_imem_addr[%0d]", i),  imem_addr,       tbl[i].exp_addr);
            chk($sformatf("t1_inst_valid[%0d]", i), 32'(inst_valid), 32'(tbl[i].exp_iv));
            chk($sformatf("t1_inst_pc[%0d]", i),    inst_pc,         tbl[i].exp_ipc);
            chk($sformatf("t1_inst[%0d]", i),       inst,            tbl[i].exp_inst);
            advance();
        end

        // 2: decode stalled, credit limit of DEPTH, then in-order drain
        do_reset();
        rv_en = 1'b1; imem_gnt = 1'b1; pc_valid = 1'b1; inst_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            to_sample();
            if (pc_valid && pc_ready) acc_cnt++;
            advance();
        end
        to_sample();
        chk("t2_accepts",     32'(acc_cnt),     32'd4);
        chk("t2_fetch_stall", 32'(fetch_stall), 32'd1);
        chk("t2_pc_ready",    32'(pc_ready),    32'd0);
        chk("t2_inst_valid",  32'(inst_valid),  32'd1);
        advance();
        pc_valid = 1'b0; inst_ready = 1'b1;
        step(8);
        chk("t2_drain_count", 32'(pop_pc_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_pc_q.size()) begin
                chk($sformatf("t2_drain_pc[%0d]", i),   pop_pc_q[i],   32'(4*i));
                chk($sformatf("t2_drain_inst[%0d]", i), pop_inst_q[i], 32'(4*i) ^ PAT);
            end
        end

        // 3: grant withheld for 5 cycles, request held stable
        do_reset();
        rv_en = 1'b1; inst_ready = 1'b1; imem_gnt = 1'b0;
        pc = 32'h100; pc_valid = 1'b1;
        to_sample();
        chk("t3_first_accept", 32'(pc_ready), 32'd1);
        advance();
        for (int i = 0; i < 5; i++) begin
            to_sample();
            chk($sformatf("t3_hold_req[%0d]", i),  32'(imem_req), 32'd1);
            chk($sformatf("t3_hold_addr[%0d]", i), imem_addr,     32'h100);
            chk($sformatf("t3_no_accept[%0d]", i), 32'(pc_ready), 32'd0);
            advance();
        end
        imem_gnt = 1'b1;
        to_sample();
        chk("t3_accept_on_gnt", 32'(pc_ready), 32'd1);
        advance();
        pc_valid = 1'b0;
        step(6);
        chk("t3_count", 32'(pop_pc_q.size()), 32'd2);
        if (pop_pc_q.size() >= 2) begin
            chk("t3_pc0", pop_pc_q[0], 32'h100);
            chk("t3_pc1", pop_pc_q[1], 32'h104);
        end

        // 4: flush with two outstanding and a third held in REQ
        do_reset();
        rv_en = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1; pc_valid = 1'b1;
        step(3);
        imem_gnt = 1'b0; pc_valid = 1'b0; flush = 1'b1;
        to_sample();
        chk("t4_flush_pc_ready", 32'(pc_ready),        32'd0);
        chk("t4_outstanding",    32'(dut.outstanding), 32'd2);
        advance();
        flush = 1'b0; pc = 32'h200; pc_valid = 1'b1; imem_gnt = 1'b1;
        to_sample();
        chk("t4_drop_cnt",      32'(dut.drop_cnt), 32'd3);
        chk("t4_inst_valid",    32'(inst_valid),   32'd0);
        chk("t4_req_held",      32'(imem_req),     32'd1);
        chk("t4_resume_accept", 32'(pc_ready),     32'd1);
        advance();
        pc_valid = 1'b0; rv_en = 1'b1;
        step(10);
        chk("t4_count", 32'(pop_pc_q.size()), 32'd1);
        if (pop_pc_q.size() >= 1) begin
            chk("t4_first_pc",   pop_pc_q[0],   32'h200);
            chk("t4_first_inst", pop_inst_q[0], 32'hA5A5A7A5);
        end
        chk("t4_drop_done", 32'(dut.drop_cnt), 32'd0);

        // 5: flush coinciding with a response and a decode pop
        do_reset();
        rv_en = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1; pc_valid = 1'b1;
        step(4);
        flush = 1'b1;
        to_sample();
        chk("t5_rvalid_at_f", 32'(imem_rvalid), 32'd1);
        chk("t5_pop_at_f",    32'(inst_valid),  32'd1);
        chk("t5_pc_at_f",     inst_pc,          32'h4);
        chk("t5_pc_ready_f",  32'(pc_ready),    32'd0);
        advance();
        flush = 1'b0; pc = 32'h300;
        to_sample();
        chk("t5_inst_valid_f1", 32'(inst_valid),     32'd0);
        chk("t5_inst_nop_f1",   inst,                NOP);
        chk("t5_drop_cnt",      32'(dut.drop_cnt),   32'd1);
        chk("t5_fifo_empty",    32'(dut.inst_count), 32'd0);
        advance();
        pc_valid = 1'b0;
        step(8);
        chk("t5_count", 32'(pop_pc_q.size()), 32'd3);
        if (pop_pc_q.size() >= 3) begin
            chk("t5_pc0", pop_pc_q[0], 32'h0);
            chk("t5_pc1", pop_pc_q[1], 32'h4);
            chk("t5_pc2", pop_pc_q[2], 32'h300);
        end

        // 6: asynchronous reset during a pending request
        do_reset();
        rv_en = 1'b1; imem_gnt = 1'b0; inst_ready = 1'b1;
        pc = 32'h40; pc_valid = 1'b1;
        step(1);
        pc_valid = 1'b0;
        to_sample();
        chk("t6_req_pending", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_req",   32'(imem_req),   32'd0);
        chk("t6_async_valid", 32'(inst_valid), 32'd0);
        chk("t6_async_addr",  imem_addr,       32'd0);
        do_reset();
        rv_en = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;
        pc = 32'h80; pc_valid = 1'b1;
        step(1);
        pc_valid = 1'b0;
        step(6);
        chk("t6_count", 32'(pop_pc_q.size()), 32'd1);
        if (pop_pc_q.size() >= 1) begin
            chk("t6_pc",   pop_pc_q[0],   32'h80);
            chk("t6_inst", pop_inst_q[0], 32'hA5A5A525);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
